// File: rtl/fa_seq_ctrl_if.sv
// Bundle between the ALU op-issue logic, the nibble sequencer and the shared 4-bit adder slice.
// The slave modport is the sequencer's view; the master modport is the issuer/slice side.
interface fa_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         of;
    logic         cf;
    logic         zf;
    logic         sf;
    logic         pf;
    logic         fa_ctrl;
    logic [3:0]   fa_a;
    logic [3:0]   fa_b;
    logic         fa_c0;
    logic [3:0]   fa_s;
    logic         fa_cf;

    modport slave (
        input  start, op, a, b, cin, fa_s, fa_cf,
        output busy, done, result, of, cf, zf, sf, pf,
        output fa_ctrl, fa_a, fa_b, fa_c0
    );

    modport master (
        output start, op, a, b, cin, fa_s, fa_cf,
        input  busy, done, result, of, cf, zf, sf, pf,
        input  fa_ctrl, fa_a, fa_b, fa_c0
    );
endinterface

// File: rtl/fa_seq_ctrl.sv
// Runs a W-bit add/subtract through one external 4-bit adder slice, one nibble per clock,
// LSB first, chaining the slice carry through a register; flags are produced at completion.
module fa_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    fa_seq_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [NIBBLES-1:0][3:0] a_q;
    logic [NIBBLES-1:0][3:0] b_q;
    logic [NIBBLES-1:0][3:0] shadow_q;
    logic [NIBBLES-1:0][3:0] shadow_d;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_d;
    logic                    carry_q;
    logic                    op_q;
    logic                    busy_q;
    logic                    done_q;
    logic [W-1:0]            result_q;
    logic                    of_q;
    logic                    cf_q;
    logic                    zf_q;
    logic                    sf_q;
    logic                    pf_q;
    logic [3:0]              fa_a_q;
    logic [3:0]              fa_b_q;
    logic                    fa_c0_q;

    logic [W-1:0]            b_in_eff;
    logic [W-1:0]            r_d;
    logic                    last_nibble;
    logic                    carry_in_eff;

    // Subtract is a + ~b + ~borrow_in, so the slice only ever adds.
    assign b_in_eff     = bus.op ? ~bus.b : bus.b;
    assign carry_in_eff = bus.op ? ~bus.cin : bus.cin;
    assign idx_d        = idx_q + 1'b1;
    assign last_nibble  = (idx_q == IW'(NIBBLES - 1));

    // Shadow including the nibble the slice is producing this cycle.
    always_comb begin
        shadow_d        = shadow_q;
        shadow_d[idx_q] = bus.fa_s;
    end

    assign r_d = shadow_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            of_q     <= 1'b0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            pf_q     <= 1'b0;
            fa_a_q   <= 4'h0;
            fa_b_q   <= 4'h0;
            fa_c0_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= b_in_eff;
                        op_q    <= bus.op;
                        carry_q <= carry_in_eff;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        fa_a_q  <= bus.a[3:0];
                        fa_b_q  <= b_in_eff[3:0];
                        fa_c0_q <= carry_in_eff;
                        state_q <= S_RUN;
                    end
                end

                S_RUN: begin
                    shadow_q <= shadow_d;
                    carry_q  <= bus.fa_cf;
                    if (last_nibble) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= r_d;
                        cf_q     <= bus.fa_cf ^ op_q;
                        of_q     <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &
                                    (r_d[W-1] != a_q[NIBBLES-1][3]);
                        zf_q     <= (r_d == '0);
                        sf_q     <= r_d[W-1];
                        pf_q     <= ~^r_d[7:0];
                        fa_a_q   <= 4'h0;
                        fa_b_q   <= 4'h0;
                        fa_c0_q  <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        // Present the next nibble so the slice sees it for the whole next cycle.
                        idx_q   <= idx_d;
                        fa_a_q  <= a_q[idx_d];
                        fa_b_q  <= b_q[idx_d];
                        fa_c0_q <= bus.fa_cf;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.of      = of_q;
    assign bus.cf      = cf_q;
    assign bus.zf      = zf_q;
    assign bus.sf      = sf_q;
    assign bus.pf      = pf_q;
    assign bus.fa_ctrl = 1'b0;
    assign bus.fa_a    = fa_a_q;
    assign bus.fa_b    = fa_b_q;
    assign bus.fa_c0   = fa_c0_q;
endmodule

// File: tb/tb_fa_seq_ctrl.sv
// Bench for fa_seq_ctrl with a behavioural 4-bit slice: directed vector table, multi-cycle
// corner sequences, back-to-back issue and randomized operations against an arithmetic model.
module tb_fa_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] res;
        logic         cf;
        logic         of;
        logic         zf;
        logic         sf;
        logic         pf;
    } rsp_t;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        rsp_t         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    fa_seq_ctrl_if #(.NIBBLES(N)) bus ();

    fa_seq_ctrl #(.NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // The shared adder slice.
    assign {bus.fa_cf, bus.fa_s} = 5'(bus.fa_a) + 5'(bus.fa_b) + 5'(bus.fa_c0);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Arithmetic reference: plain integer add/subtract with borrow and signed range checks.
    function automatic rsp_t model(input logic op_v, input logic [W-1:0] a_v,
                                   input logic [W-1:0] b_v, input logic cin_v);
        rsp_t        r;
        longint      ua, ub, sa, sb, c, full, sr;
        logic [63:0] fv;
        ua = longint'(a_v);
        ub = longint'(b_v);
        sa = longint'($signed(a_v));
        sb = longint'($signed(b_v));
        c  = longint'(cin_v);
        if (!op_v) begin
            full = ua + ub + c;
            sr   = sa + sb + c;
            r.cf = (full >= (longint'(1) << W));
        end else begin
            full = ua - ub - c;
            sr   = sa - sb - c;
            r.cf = (full < 0);
        end
        fv    = 64'(full);
        r.res = fv[W-1:0];
        r.of  = (sr > (longint'(1) << (W - 1)) - 1) || (sr < -(longint'(1) << (W - 1)));
        r.zf  = (r.res == '0);
        r.sf  = r.res[W-1];
        r.pf  = ($countones(r.res[7:0]) % 2 == 0);
        return r;
    endfunction

    function automatic rsp_t sample_rsp();
        rsp_t r;
        r.res = bus.result;
        r.cf  = bus.cf;
        r.of  = bus.of;
        r.zf  = bus.zf;
        r.sf  = bus.sf;
        r.pf  = bus.pf;
        return r;
    endfunction

    task automatic chk_rsp(input string tag, input rsp_t got, input rsp_t exp);
        chk({tag, ".result"}, 32'(got.res), 32'(exp.res));
        chk({tag, ".cf"}, 32'(got.cf), 32'(exp.cf));
        chk({tag, ".of"}, 32'(got.of), 32'(exp.of));
        chk({tag, ".zf"}, 32'(got.zf), 32'(exp.zf));
        chk({tag, ".sf"}, 32'(got.sf), 32'(exp.sf));
        chk({tag, ".pf"}, 32'(got.pf), 32'(exp.pf));
    endtask

    // Slice mode is always add; slice inputs are quiet whenever the sequencer is not running.
    always @(negedge clk) begin
        chk("fa_ctrl", 32'(bus.fa_ctrl), 32'd0);
        if (!bus.busy) chk("fa_idle", {23'd0, bus.fa_a, bus.fa_b, bus.fa_c0}, 32'd0);
    end

    // Drive a request and return #1 after the edge that accepts it; inputs are then scrambled.
    task automatic start_op(input logic op_v, input logic [W-1:0] a_v,
                            input logic [W-1:0] b_v, input logic cin_v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.a     = a_v;
        bus.b     = b_v;
        bus.cin   = cin_v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 1'($urandom_range(0, 1));
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom_range(0, 1));
    endtask

    // Count edges until done is seen; busy_n counts cycles with busy high (including the current one).
    task automatic wait_done(output int edges, output int busy_n);
        edges  = 0;
        busy_n = bus.busy ? 1 : 0;
        while (edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.done) break;
            if (bus.busy) busy_n++;
        end
        if (!bus.done) begin
            edges = -1;
            checks++;
            errors++;
            $display("FAIL done_timeout got=no_done expected=done_within_20");
        end
    endtask

    task automatic run_op(input string tag, input logic op_v, input logic [W-1:0] a_v,
                          input logic [W-1:0] b_v, input logic cin_v, input rsp_t exp);
        int   edges, busy_n;
        rsp_t got;
        start_op(op_v, a_v, b_v, cin_v);
        wait_done(edges, busy_n);
        got = sample_rsp();
        $display("%s op=%0d a=%h b=%h cin=%0d -> result=%h cf=%0d of=%0d zf=%0d sf=%0d pf=%0d edges=%0d",
                 tag, op_v, a_v, b_v, cin_v, got.res, got.cf, got.of, got.zf, got.sf, got.pf, edges);
        chk_rsp(tag, got, exp);
        // done first seen N edges after acceptance, i.e. consumed by edge N+1.
        chk({tag, ".latency"}, 32'(edges), 32'(N));
        chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(N));
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin : main
        int   edges, busy_n, n_done, last_done;
        rsp_t got, exp;
        logic         op_v, cin_v;
        logic [W-1:0] a_v, b_v;
        rsp_t         q_exp[$];

        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[1] = '{1'b1, 16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}};
        vecs[5] = '{1'b0, 16'h00FF, 16'h0000, 1'b1, '{16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[6] = '{1'b0, 16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[7] = '{1'b1, 16'h1234, 16'h1234, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}};

        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        // Reset state
        #2;
        chk("reset.busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("reset.result", 32'(bus.result), 32'd0);
        chk("reset.flags", {27'd0, bus.of, bus.cf, bus.zf, bus.sf, bus.pf}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);
        end

        // start pulsed in the 2nd RUN cycle is ignored
        start_op(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(edges, busy_n);
        got = sample_rsp();
        $display("midstart op=0 a=1234 b=0fff -> result=%h edges=%0d", got.res, edges);
        chk_rsp("midstart", got, vecs[0].exp);
        n_done = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        chk("midstart.no_extra_done", 32'(n_done), 32'd0);

        // Reset in the 3rd RUN cycle aborts; result was nonzero beforehand
        start_op(1'b0, 16'h5555, 16'h1111, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("abort.busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        $display("abort rst in RUN3 -> busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);
        chk("abort.busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("abort.result", 32'(bus.result), 32'd0);
        chk("abort.flags", {27'd0, bus.of, bus.cf, bus.zf, bus.sf, bus.pf}, 32'd0);
        chk("abort.fa", {23'd0, bus.fa_a, bus.fa_b, bus.fa_c0}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        chk("abort.no_done", 32'(n_done), 32'd0);
        run_op("post_abort", 1'b0, 16'h0001, 16'h0001, 1'b0, vecs[6].exp);

        // Back-to-back with start held high: one operation every N+2 cycles
        @(negedge clk);
        op_v  = 1'($urandom_range(0, 1));
        a_v   = W'($urandom);
        b_v   = W'($urandom);
        cin_v = 1'($urandom_range(0, 1));
        q_exp.push_back(model(op_v, a_v, b_v, cin_v));
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.a     = a_v;
        bus.b     = b_v;
        bus.cin   = cin_v;
        last_done = -1;
        for (int j = 0; j < 4; j++) begin
            wait_done(edges, busy_n);
            got = sample_rsp();
            exp = q_exp.pop_front();
            $display("b2b%0d -> result=%h cf=%0d of=%0d done_cycle=%0d", j, got.res, got.cf, got.of, cyc);
            chk_rsp($sformatf("b2b%0d", j), got, exp);
            if (last_done >= 0) chk($sformatf("b2b%0d.period", j), 32'(cyc - last_done), 32'(N + 2));
            last_done = cyc;
            if (j == 3) begin
                bus.start = 1'b0;
            end else begin
                op_v  = 1'($urandom_range(0, 1));
                a_v   = W'($urandom);
                b_v   = W'($urandom);
                cin_v = 1'($urandom_range(0, 1));
                q_exp.push_back(model(op_v, a_v, b_v, cin_v));
                bus.op  = op_v;
                bus.a   = a_v;
                bus.b   = b_v;
                bus.cin = cin_v;
            end
        end
        repeat (3) @(posedge clk);

        // Randomized operations against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            op_v  = 1'($urandom_range(0, 1));
            a_v   = W'($urandom);
            b_v   = (k % 5 == 0) ? a_v : W'($urandom);
            cin_v = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", k), op_v, a_v, b_v, cin_v, model(op_v, a_v, b_v, cin_v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
